// File: rtl/pipe_control.sv
// ID/EX pipeline control: opcode decode, load-use hazard detection,
// ID/EX control register with flush/hold priority and a stall counter.
module pipe_control #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              ex_hold_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    output logic [1:0]        ex_aluop_o,
    output logic              ex_alusrc_o,
    output logic              ex_regwrite_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_memtoreg_o,
    output logic              ex_branch_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              hazard_stall_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
    } ctrl_t;

    logic op_r;
    logic op_i;
    logic op_ld;
    logic op_st;
    logic op_br;

    ctrl_t dec_ctrl;
    logic  dec_legal;
    logic  use_rs1;
    logic  use_rs2;

    logic              ex_valid_q;
    logic              ex_valid_d;
    ctrl_t             ex_ctrl_q;
    ctrl_t             ex_ctrl_d;
    logic [REG_AW-1:0] ex_rd_q;
    logic [REG_AW-1:0] ex_rd_d;
    logic              illegal_q;
    logic              illegal_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    logic rs1_hit;
    logic rs2_hit;
    logic hazard;
    logic load_slot;

    assign op_r  = (opcode_i == OP_R);
    assign op_i  = (opcode_i == OP_I);
    assign op_ld = (opcode_i == OP_LD);
    assign op_st = (opcode_i == OP_ST);
    assign op_br = (opcode_i == OP_BR);

    always_comb begin
        dec_ctrl  = '0;
        dec_legal = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        unique case (1'b1)
            op_r: begin
                dec_ctrl  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
                dec_legal = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            op_i: begin
                dec_ctrl  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
                dec_legal = 1'b1;
                use_rs1   = 1'b1;
            end
            op_ld: begin
                dec_ctrl  = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
                dec_legal = 1'b1;
                use_rs1   = 1'b1;
            end
            op_st: begin
                dec_ctrl  = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
                dec_legal = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            op_br: begin
                dec_ctrl  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
                dec_legal = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            default: ;
        endcase
    end

    // ex_rd_q is already zero for non-writing instructions and bubbles
    assign rs1_hit = use_rs1 && (rs1_i == ex_rd_q);
    assign rs2_hit = use_rs2 && (rs2_i == ex_rd_q);
    assign hazard  = ex_valid_q && ex_ctrl_q.memread && (ex_rd_q != '0)
                     && id_valid_i && (rs1_hit || rs2_hit);

    assign hazard_stall_o = hazard && !flush_i && !ex_hold_i;
    assign load_slot      = !flush_i && !ex_hold_i && !hazard;

    always_comb begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
        ex_rd_d    = '0;
        if (!flush_i && ex_hold_i) begin
            ex_valid_d = ex_valid_q;
            ex_ctrl_d  = ex_ctrl_q;
            ex_rd_d    = ex_rd_q;
        end else if (load_slot && id_valid_i) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = dec_ctrl;
            ex_rd_d    = dec_ctrl.regwrite ? rd_i : '0;
        end
    end

    assign illegal_d = load_slot && id_valid_i && !dec_legal;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rd_q     <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_aluop_o    = ex_ctrl_q.aluop;
    assign ex_alusrc_o   = ex_ctrl_q.alusrc;
    assign ex_regwrite_o = ex_ctrl_q.regwrite;
    assign ex_memread_o  = ex_ctrl_q.memread;
    assign ex_memwrite_o = ex_ctrl_q.memwrite;
    assign ex_memtoreg_o = ex_ctrl_q.memtoreg;
    assign ex_branch_o   = ex_ctrl_q.branch;
    assign ex_rd_o       = ex_rd_q;
    assign illegal_o     = illegal_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule
